// File: rtl/expr_result_pkg.sv
// expr_result_pkg: shared widths, MISR constants, FSM states and the MISR step function
package expr_result_pkg;
  localparam int Y_W = 90;
  localparam int SIG_W = 32;
  localparam int CNT_W = 16;
  localparam logic [SIG_W-1:0] POLY = 32'h04C11DB7;
  localparam logic [SIG_W-1:0] SEED = 32'hFFFFFFFF;
  typedef enum logic [2:0] {IDLE, RUN, FOLD0, FOLD1, FOLD2, DONE} state_t;
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig, input logic [SIG_W-1:0] chunk);
    return {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ chunk;
  endfunction
endpackage

// File: rtl/expr_misr_core.sv
// expr_misr_core: signature register advanced by one MISR step per enabled cycle
module expr_misr_core
  import expr_result_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_seed,
  input  logic             step_en,
  input  logic [SIG_W-1:0] chunk,
  output logic [SIG_W-1:0] signature
);
  // seed load takes priority so a restart discards any in-flight fold step
  always_ff @(posedge clk or posedge rst)
    if (rst) signature <= SEED;
    else if (load_seed) signature <= SEED;
    else if (step_en) signature <= misr_step(signature, chunk);
endmodule

// File: rtl/expr_result_misr.sv
// expr_result_misr: folds 90-bit result vectors into a 32-bit MISR signature; EXPR_RESULT_MISR_STALL_CNT_EN adds stall_count
module expr_result_misr
  import expr_result_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Y_W-1:0]   in_y,
  output logic             busy,
  output logic             sig_valid,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] vec_count
`ifdef EXPR_RESULT_MISR_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_count
`endif
);
  state_t state, state_next;
  logic [CNT_W-1:0] target;
  logic [Y_W-1:0] hold_q;
  logic accept, step_en;
  logic [SIG_W-1:0] chunk;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_next;
  // next state and handshake/status outputs; start restarts from any state
  always_comb begin
    state_next = state;
    in_ready = state == RUN;
    busy = state inside {RUN, FOLD0, FOLD1, FOLD2};
    sig_valid = state == DONE;
    accept = in_ready && in_valid && !start;
    step_en = !start && (state inside {FOLD0, FOLD1, FOLD2});
    chunk = state == FOLD0 ? hold_q[SIG_W-1:0] :
            state == FOLD1 ? hold_q[2*SIG_W-1:SIG_W] :
            {{(3*SIG_W-Y_W){1'b0}}, hold_q[Y_W-1:2*SIG_W]};
    if (start) state_next = RUN;
    else if (state == RUN && in_valid) state_next = FOLD0;
    else if (state == FOLD0) state_next = FOLD1;
    else if (state == FOLD1) state_next = FOLD2;
    else if (state == FOLD2) state_next = vec_count == target ? DONE : RUN;
  end
  // run target, accepted-vector count and captured vector
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      target <= '0;
      vec_count <= '0;
      hold_q <= '0;
    end else if (start) begin
      target <= num_vec == '0 ? CNT_W'(1) : num_vec;
      vec_count <= '0;
    end else if (accept) begin
      hold_q <= in_y;
      if (vec_count != target) vec_count <= vec_count + 1'b1;
    end
  expr_misr_core u_core (
    .clk(clk),
    .rst(rst),
    .load_seed(start),
    .step_en(step_en),
    .chunk(chunk),
    .signature(signature)
  );
`ifdef EXPR_RESULT_MISR_STALL_CNT_EN
  // RUN cycles with no vector offered, saturating
  always_ff @(posedge clk or posedge rst)
    if (rst) stall_count <= '0;
    else if (start) stall_count <= '0;
    else if (state == RUN && !in_valid && stall_count != '1) stall_count <= stall_count + 1'b1;
`endif
endmodule

// File: tb/tb_expr_result_misr.sv
// tb_expr_result_misr: scoreboard bench for expr_result_misr
module tb_expr_result_misr;
  import expr_result_pkg::*;
  logic clk = 0, rst, start, in_valid, in_ready, busy, sig_valid;
  logic [CNT_W-1:0] num_vec, vec_count;
  logic [Y_W-1:0] in_y;
  logic [SIG_W-1:0] signature;
`ifdef EXPR_RESULT_MISR_STALL_CNT_EN
  logic [CNT_W-1:0] stall_count;
`endif
  typedef struct {logic [31:0] sig; logic [31:0] cnt;} exp_t;
  exp_t sb[$];
  logic [Y_W-1:0] vecs[8];
  int vectors = 0, miscompares = 0;
  expr_result_misr dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .in_valid(in_valid),
    .in_ready(in_ready), .in_y(in_y), .busy(busy), .sig_valid(sig_valid),
    .signature(signature), .vec_count(vec_count)
`ifdef EXPR_RESULT_MISR_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask
  function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [31:0] c);
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ c;
  endfunction
  task automatic expect_run(input int n);
    logic [31:0] s = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      s = ref_step(s, vecs[i][31:0]);
      s = ref_step(s, vecs[i][63:32]);
      s = ref_step(s, {6'b0, vecs[i][89:64]});
    end
    sb.push_back('{s, 32'(n)});
  endtask
  task automatic rand_vecs();
    for (int i = 0; i < 8; i++) vecs[i] = Y_W'({$urandom, $urandom, $urandom});
  endtask
  task automatic do_start(input int n);
    @(negedge clk);
    start = 1;
    num_vec = CNT_W'(n);
    @(negedge clk);
    start = 0;
  endtask
  task automatic send_vecs(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      int cyc = 0;
      in_y = vecs[i];
      in_valid = 1;
      while (!in_ready && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      check("in_ready", 32'(in_ready), 1);
      if (i > first) check("ready_gap", cyc, 3);
      @(negedge clk);
    end
    in_valid = 0;
  endtask
  task automatic wait_done();
    int lat = 1;
    exp_t e;
    check("sig_valid_early", 32'(sig_valid), 0);
    while (!sig_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 4);
    check("sig_valid", 32'(sig_valid), 1);
    check("busy_done", 32'(busy), 0);
    if (sb.size() == 0) check("sb_size", 0, 1);
    else begin
      e = sb.pop_front();
      check("signature", signature, e.sig);
      check("vec_count", 32'(vec_count), e.cnt);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    rst = 1; start = 0; in_valid = 0; num_vec = 0; in_y = 0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_sig_valid", 32'(sig_valid), 0);
    check("rst_signature", signature, 32'hFFFFFFFF);
    check("rst_vec_count", 32'(vec_count), 0);
    rst = 0;
    vecs[0] = '0;
    expect_run(1);
    do_start(1);
    check("run_busy", 32'(busy), 1);
    send_vecs(0, 1);
    wait_done();
    check("zero_sig_const", signature, 32'hE1B8AFFD);
    rand_vecs();
    expect_run(3);
    do_start(3);
    send_vecs(0, 3);
    wait_done();
    vecs[0] = '0;
    expect_run(1);
    do_start(0);
    send_vecs(0, 1);
    wait_done();
    check("nv0_sig_const", signature, 32'hE1B8AFFD);
    in_y = Y_W'({$urandom, $urandom, $urandom});
    in_valid = 1;
    repeat (3) @(negedge clk);
    check("done_in_ready", 32'(in_ready), 0);
    check("done_vec_count", 32'(vec_count), 1);
    check("done_signature", signature, 32'hE1B8AFFD);
    in_valid = 0;
    rand_vecs();
    do_start(4);
    send_vecs(0, 2);
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    check("restart_count", 32'(vec_count), 0);
    check("restart_ready", 32'(in_ready), 1);
    expect_run(4);
    send_vecs(0, 4);
    wait_done();
    rand_vecs();
    do_start(2);
    in_y = vecs[7];
    in_valid = 1;
    start = 1;
    @(negedge clk);
    start = 0;
    in_valid = 0;
    check("start_wins_count", 32'(vec_count), 0);
    check("start_wins_ready", 32'(in_ready), 1);
    expect_run(2);
    send_vecs(0, 2);
    wait_done();
    do_start(2);
    send_vecs(0, 1);
    repeat (2) @(negedge clk);
    check("fold2_busy", 32'(busy), 1);
    #1 rst = 1;
    #1;
    check("arst_in_ready", 32'(in_ready), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_sig_valid", 32'(sig_valid), 0);
    check("arst_signature", signature, 32'hFFFFFFFF);
    check("arst_vec_count", 32'(vec_count), 0);
    @(negedge clk);
    rst = 0;
    in_valid = 1;
    repeat (3) @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 0);
    check("post_rst_busy", 32'(busy), 0);
    in_valid = 0;
`ifdef EXPR_RESULT_MISR_STALL_CNT_EN
    rand_vecs();
    expect_run(2);
    do_start(2);
    check("stall_clear", 32'(stall_count), 0);
    for (int v = 0; v < 2; v++) begin
      int cyc = 0;
      while (!in_ready && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      repeat (5) @(negedge clk);
      send_vecs(v, 1);
    end
    wait_done();
    check("stall_count", 32'(stall_count), 10);
    repeat (3) @(negedge clk);
    check("stall_frozen", 32'(stall_count), 10);
`endif
    check("sb_left", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
